// File: rtl/drac_pkg.sv
// Shared types for the SIMD datapath: instruction/element-width encodings and
// the result collector's reduction state plus element-width helpers.
package drac_pkg;

  localparam int SIMD_N_LANES = 2;

  typedef enum logic [2:0] {
    VADD,
    VSUB,
    VAND,
    VOR,
    VXOR,
    VREDSUM,
    VMV
  } instr_type_t;

  typedef enum logic [1:0] {
    SEW_8,
    SEW_16,
    SEW_32,
    SEW_64
  } sew_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FOLD,
    FINAL
  } collector_state_t;

  // Mask covering one element of the given width, aligned at bit 0.
  function automatic logic [63:0] sew_mask(sew_t sew);
    case (sew)
      SEW_8:   return 64'h0000_0000_0000_00FF;
      SEW_16:  return 64'h0000_0000_0000_FFFF;
      SEW_32:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Halving steps needed to fold a 64-bit word down to one element.
  function automatic logic [1:0] fold_steps(sew_t sew);
    case (sew)
      SEW_8:   return 2'd3;
      SEW_16:  return 2'd2;
      SEW_32:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/simd_result_collector_if.sv
// Lane-result input bus and writeback output bus of the SIMD result collector.
// The slave modport is the collector; the master modport is its environment.
interface simd_result_collector_if
  import drac_pkg::*;
#(
  parameter int N_LANES = SIMD_N_LANES
) ();

  logic                    valid_i;
  logic                    ready_o;
  instr_type_t             instr_type_i;
  sew_t                    sew_i;
  logic [4:0]              vd_i;
  logic [N_LANES*64-1:0]   lane_data_i;
  logic [63:0]             scalar_i;

  logic                    valid_o;
  logic                    ready_i;
  logic [4:0]              vd_o;
  logic [N_LANES*64-1:0]   data_o;
  logic                    busy_o;

  modport master (
    output valid_i, instr_type_i, sew_i, vd_i, lane_data_i, scalar_i, ready_i,
    input  ready_o, valid_o, vd_o, data_o, busy_o
  );

  modport slave (
    input  valid_i, instr_type_i, sew_i, vd_i, lane_data_i, scalar_i, ready_i,
    output ready_o, valid_o, vd_o, data_o, busy_o
  );

endinterface

// File: rtl/simd_packed_add.sv
// 64-bit packed adder: byte-wise carry chain with the carry cut at every
// element boundary selected by sew, so each element wraps independently.
module simd_packed_add
  import drac_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  sew_t        sew,
  output logic [63:0] sum
);

  always_comb begin
    logic       carry;
    logic       elem_start;
    logic [8:0] byte_sum;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    sum        = '0;
    carry      = 1'b0;
    elem_start = 1'b0;
    byte_sum   = '0;
    for (int i = 0; i < 8; i++) begin
      case (sew)
        SEW_8:   elem_start = 1'b1;
        SEW_16:  elem_start = (i % 2) == 0;
        SEW_32:  elem_start = (i % 4) == 0;
        default: elem_start = (i == 0);
      endcase
      if (elem_start) carry = 1'b0;
      byte_sum         = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]} + {8'd0, carry};
      sum[i*8 +: 8]    = byte_sum[7:0];
      carry            = byte_sum[8];
    end
  end

endmodule

// File: rtl/simd_result_collector.sv
// Collects per-lane SIMD results, reduces VREDSUM across lanes and elements,
// and queues every result in an in-order FIFO toward vector writeback.
module simd_result_collector
  import drac_pkg::*;
#(
  parameter int N_LANES    = SIMD_N_LANES,
  parameter int FIFO_DEPTH = 2
) (
  input logic                    clk_i,
  input logic                    rst_i,
  simd_result_collector_if.slave bus
);

  localparam int DATA_W = N_LANES * 64;
  localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  collector_state_t  state_q, state_d;
  logic [63:0]       acc_q, acc_d;
  logic [63:0]       scalar_q;
  logic [63:0]       lanes_q [N_LANES];
  sew_t              sew_q;
  logic [4:0]        vd_q;
  logic [LANE_W-1:0] lane_idx_q, lane_idx_d;
  logic [1:0]        fold_cnt_q, fold_cnt_d;

  logic [63:0]       add_b, add_sum, red_res;
  logic [5:0]        fold_shift;
  logic              ready, accept, red_accept, pass_accept, red_push;

  logic              push, pop, fifo_full, fifo_empty;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [4:0]        mem_vd   [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [4:0]        push_vd;
  logic [DATA_W-1:0] push_data;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign ready       = (state_q == IDLE) && !fifo_full;
  assign accept      = bus.valid_i && ready;
  assign red_accept  = accept && (bus.instr_type_i == VREDSUM);
  assign pass_accept = accept && (bus.instr_type_i != VREDSUM);

  // One adder serves all reduction phases; only its second operand changes.
  assign fold_shift = 6'd32 >> fold_cnt_q;

  always_comb begin
    add_b = '0;
    case (state_q)
      ACCUM:   add_b = lanes_q[lane_idx_q];
      FOLD:    add_b = acc_q >> fold_shift;
      FINAL:   add_b = scalar_q;
      default: add_b = '0;
    endcase
  end

  simd_packed_add u_add (
    .a   (acc_q),
    .b   (add_b),
    .sew (sew_q),
    .sum (add_sum)
  );

  assign red_res = add_sum & sew_mask(sew_q);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    lane_idx_d = lane_idx_q;
    fold_cnt_d = fold_cnt_q;
    red_push   = 1'b0;
    case (state_q)
      IDLE: begin
        if (red_accept) begin
          acc_d      = bus.lane_data_i[63:0];
          lane_idx_d = LANE_W'(1);
          fold_cnt_d = '0;
          if (N_LANES > 1)               state_d = ACCUM;
          else if (bus.sew_i == SEW_64)  state_d = FINAL;
          else                           state_d = FOLD;
        end
      end
      ACCUM: begin
        acc_d = add_sum;
        if (lane_idx_q == LANE_W'(N_LANES - 1)) begin
          state_d = (sew_q == SEW_64) ? FINAL : FOLD;
        end else begin
          lane_idx_d = lane_idx_q + LANE_W'(1);
        end
      end
      FOLD: begin
        acc_d = add_sum;
        if (fold_cnt_q == fold_steps(sew_q) - 2'd1) state_d = FINAL;
        else                                         fold_cnt_d = fold_cnt_q + 2'd1;
      end
      FINAL: begin
        // A full FIFO holds the result here until writeback frees a slot.
        if (!fifo_full) begin
          red_push = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      lane_idx_q <= '0;
      fold_cnt_q <= '0;
      sew_q      <= SEW_8;
      vd_q       <= '0;
      scalar_q   <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      lane_idx_q <= lane_idx_d;
      fold_cnt_q <= fold_cnt_d;
      if (red_accept) begin
        sew_q    <= bus.sew_i;
        vd_q     <= bus.vd_i;
        scalar_q <= bus.scalar_i;
      end
    end
  end

  // NOTE: operand and FIFO storage are not reset; the state and count gate every use of them.
  always_ff @(posedge clk_i) begin
    if (red_accept) begin
      for (int k = 0; k < N_LANES; k++) lanes_q[k] <= bus.lane_data_i[k*64 +: 64];
    end
  end

  always_comb begin
    push_vd   = bus.vd_i;
    push_data = bus.lane_data_i;
    if (red_push) begin
      push_vd         = vd_q;
      push_data       = '0;
      push_data[63:0] = red_res;
    end
  end

  assign push = pass_accept || red_push;
  assign pop  = !fifo_empty && bus.ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_vd[wr_ptr_q]   <= push_vd;
      mem_data[wr_ptr_q] <= push_data;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = !fifo_empty;
  assign bus.vd_o    = fifo_empty ? '0 : mem_vd[rd_ptr_q];
  assign bus.data_o  = fifo_empty ? '0 : mem_data[rd_ptr_q];
  assign bus.busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_simd_result_collector.sv
// Self-checking bench for simd_result_collector: directed latency/value cases
// and a randomized run scored against an element-wise arithmetic model.
module tb_simd_result_collector;
  import drac_pkg::*;

  localparam int N  = 2;
  localparam int DW = N * 64;

  typedef struct {
    logic [4:0]    vd;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simd_result_collector_if #(.N_LANES(N)) bus ();

  simd_result_collector #(.N_LANES(N), .FIFO_DEPTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   accepts  = 0;
  int   pops     = 0;
  bit   last_accept;
  exp_t exp_q[$];

  task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sum every SEW element of every lane plus the scalar, mod 2^SEW.
  function automatic logic [DW-1:0] model(instr_type_t it, sew_t s,
                                          logic [DW-1:0] lanes, logic [63:0] sc);
    int          w;
    logic [63:0] m, sum, lane;
    if (it != VREDSUM) return lanes;
    w   = 8 << int'(s);
    m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    sum = sc & m;
    for (int k = 0; k < N; k++) begin
      lane = lanes[k*64 +: 64];
      for (int e = 0; e < 64 / w; e++) sum += (lane >> (e * w)) & m;
    end
    return DW'(sum & m);
  endfunction

  task automatic drive(instr_type_t it, sew_t s, logic [4:0] vd,
                       logic [DW-1:0] lanes, logic [63:0] sc);
    bus.valid_i      = 1'b1;
    bus.instr_type_i = it;
    bus.sew_i        = s;
    bus.vd_i         = vd;
    bus.lane_data_i  = lanes;
    bus.scalar_i     = sc;
  endtask

  // Called at a falling edge: scores the accept/pop that the next rising edge performs.
  task automatic tick();
    exp_t e;
    last_accept = 1'b0;
    if (!rst && bus.valid_i && bus.ready_o) begin
      last_accept = 1'b1;
      accepts++;
      e.vd   = bus.vd_i;
      e.data = model(bus.instr_type_i, bus.sew_i, bus.lane_data_i, bus.scalar_i);
      exp_q.push_back(e);
    end
    if (!rst && bus.valid_o && bus.ready_i) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_pop", DW'(bus.valid_o), '0);
      end else begin
        e = exp_q.pop_front();
        check("pop_vd", DW'(bus.vd_o), DW'(e.vd));
        check("pop_data", bus.data_o, e.data);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (last_accept) bus.valid_i = 1'b0;
  endtask

  task automatic send(string tag, instr_type_t it, sew_t s, logic [4:0] vd,
                      logic [DW-1:0] lanes, logic [63:0] sc);
    drive(it, s, vd, lanes, sc);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_accept) break;
    end
    check(tag, DW'(last_accept), DW'(1));
  endtask

  // First falling edge after the accept counts as cycle 1.
  task automatic wait_valid(string tag, int exp_lat);
    int lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.valid_o) begin
        lat = n;
        break;
      end
      tick();
    end
    check(tag, DW'(lat), DW'(exp_lat));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, pop0;
    bus.valid_i      = 1'b0;
    bus.instr_type_i = VADD;
    bus.sew_i        = SEW_8;
    bus.vd_i         = '0;
    bus.lane_data_i  = '0;
    bus.scalar_i     = '0;
    bus.ready_i      = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", DW'(bus.valid_o), '0);
    check("rst_ready", DW'(bus.ready_o), DW'(1));
    check("rst_busy",  DW'(bus.busy_o),  '0);
    check("rst_data",  bus.data_o,       '0);
    check("rst_vd",    DW'(bus.vd_o),    '0);
    rst = 1'b0;

    // Pass-through VADD, latency 1.
    bus.ready_i = 1'b1;
    send("t1_accept", VADD, SEW_32, 5'd3,
         {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 64'd0);
    check("t1_valid", DW'(bus.valid_o), DW'(1));
    check("t1_data",  bus.data_o, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    check("t1_vd",    DW'(bus.vd_o), DW'(3));
    tick();
    check("t1_empty", DW'(bus.valid_o), '0);

    send("t2_accept", VREDSUM, SEW_8, 5'd5,
         {64'h0101_0101_0101_0101, 64'h0102_0304_0506_0708}, 64'h10);
    wait_valid("t2_latency", 6);
    check("t2_data", bus.data_o, DW'(64'h3C));
    check("t2_vd",   DW'(bus.vd_o), DW'(5));
    check("t2_busy", DW'(bus.busy_o), '0);
    tick();

    send("t3_accept", VREDSUM, SEW_16, 5'd7, '1, 64'd0);
    wait_valid("t3_latency", 5);
    check("t3_data", bus.data_o, DW'(64'hFFF8));
    tick();

    send("t4_accept", VREDSUM, SEW_64, 5'd9, {64'd7, 64'd5}, 64'd1);
    wait_valid("t4_latency", 3);
    check("t4_data", bus.data_o, DW'(64'd13));
    tick();

    // Back-pressure: third VOR must wait for a free slot, then all drain in order.
    bus.ready_i = 1'b0;
    acc0 = accepts;
    pop0 = pops;
    send("t5_accept_a", VOR, SEW_64, 5'd1, {64'hA1, 64'hA0}, 64'd0);
    send("t5_accept_b", VOR, SEW_64, 5'd2, {64'hB1, 64'hB0}, 64'd0);
    check("t5_ready_full", DW'(bus.ready_o), '0);
    drive(VOR, SEW_64, 5'd3, {64'hC1, 64'hC0}, 64'd0);
    tick();
    tick();
    check("t5_third_held", DW'(accepts - acc0), DW'(2));
    bus.ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!bus.valid_i && exp_q.size() == 0 && !bus.valid_o) break;
      tick();
    end
    check("t5_pops",  DW'(pops - pop0), DW'(3));
    check("t5_drain", DW'(exp_q.size()), '0);

    // Reset mid-FOLD with one entry pending.
    bus.ready_i = 1'b0;
    send("t6_accept_a", VADD, SEW_8, 5'd4, {64'h1, 64'h2}, 64'd0);
    send("t6_accept_r", VREDSUM, SEW_8, 5'd6, {64'h3, 64'h4}, 64'd0);
    tick();
    check("t6_busy_fold", DW'(bus.busy_o), DW'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_valid", DW'(bus.valid_o), '0);
    check("t6_busy",  DW'(bus.busy_o),  '0);
    check("t6_ready", DW'(bus.ready_o), DW'(1));
    check("t6_data",  bus.data_o,       '0);
    exp_q.delete();
    rst = 1'b0;

    // Randomized mix with random writeback back-pressure.
    for (int i = 0; i < 600; i++) begin
      if (!bus.valid_i && $urandom_range(0, 3) != 0) begin
        drive(($urandom_range(0, 9) < 4) ? VREDSUM : instr_type_t'($urandom_range(0, 4)),
              sew_t'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
      end
      bus.ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end

    bus.ready_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!bus.valid_i && exp_q.size() == 0 && !bus.valid_o) break;
      tick();
    end
    check("drain_queue", DW'(exp_q.size()), '0);
    check("drain_valid", DW'(bus.valid_o), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
